// File: rtl/counter_updown_mod.sv
// counter_updown_mod: parametrised up/down counter with programmable modulo,
// wrap or saturate at the limits, synchronous clear/load, and a registered
// one-cycle terminal-count pulse for cascading.
// Optional build macro COUNTER_PRESCALE_EN adds an enabled-cycle prescaler:
// a count step then needs PRESCALE enabled cycles instead of one.
module counter_updown_mod #(
  parameter int WIDTH    = 4,
  parameter int MAX_VAL  = 2**WIDTH-1,
  parameter int MODE     = 0,
  parameter int PRESCALE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             up,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             at_limit
);

  localparam logic [WIDTH-1:0] MAX_W  = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] MAX_M1 = WIDTH'(MAX_VAL-1);
  localparam logic [WIDTH-1:0] ONE_W  = WIDTH'(1);
  localparam bit               SAT    = (MODE == 1);

  // Reject illegal configurations at elaboration.
  if (WIDTH < 1) begin : g_bad_width
    $error("counter_updown_mod: WIDTH must be >= 1");
  end
  if ((MAX_VAL < 1) || (MAX_VAL > (2**WIDTH)-1)) begin : g_bad_max
    $error("counter_updown_mod: MAX_VAL out of range 1..2**WIDTH-1");
  end
  if ((MODE != 0) && (MODE != 1)) begin : g_bad_mode
    $error("counter_updown_mod: MODE must be 0 or 1");
  end
  if (PRESCALE < 1) begin : g_bad_pre
    $error("counter_updown_mod: PRESCALE must be >= 1");
  end

  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             step;

`ifdef COUNTER_PRESCALE_EN
  // At least one bit so PRESCALE=1 still elaborates; it then stays at 0.
  localparam int           PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE-1);
  logic [PW-1:0] pre_q, pre_d;
`endif

  // Next-state: clr beats load beats enable; tc only on a boundary event.
  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    step    = 1'b0;
`ifdef COUNTER_PRESCALE_EN
    pre_d   = pre_q;
`endif
    if (clr) begin
      count_d = '0;
`ifdef COUNTER_PRESCALE_EN
      pre_d   = '0;
`endif
    end else if (load) begin
      count_d = (load_val > MAX_W) ? MAX_W : load_val;
`ifdef COUNTER_PRESCALE_EN
      pre_d   = '0;
`endif
    end else if (enable) begin
`ifdef COUNTER_PRESCALE_EN
      if (pre_q == PRE_LAST) begin
        pre_d = '0;
        step  = 1'b1;
      end else begin
        pre_d = pre_q + 1'b1;
      end
`else
      step = 1'b1;
`endif
    end

    if (step) begin
      if (up) begin
        if (count_q == MAX_W) begin
          // Saturate: already at the limit, hold with no pulse.
          if (!SAT) begin
            count_d = '0;
            tc_d    = 1'b1;
          end
        end else begin
          count_d = count_q + 1'b1;
          tc_d    = SAT && (count_q == MAX_M1);
        end
      end else begin
        if (count_q == '0) begin
          if (!SAT) begin
            count_d = MAX_W;
            tc_d    = 1'b1;
          end
        end else begin
          count_d = count_q - 1'b1;
          tc_d    = SAT && (count_q == ONE_W);
        end
      end
    end
  end

  // State registers; reset clears everything including any pending tc.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      tc_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
    end
  end

`ifdef COUNTER_PRESCALE_EN
  // Prescaler register, cleared with the counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pre_q <= '0;
    else        pre_q <= pre_d;
  end
`endif

  assign count    = count_q;
  assign tc       = tc_q;
  assign at_limit = up ? (count_q == MAX_W) : (count_q == '0);

endmodule

// File: tb/tb_counter_updown_mod.sv
// Scoreboard bench for counter_updown_mod. Four instances share one input
// set; each queued expectation names the instance it applies to.
//   d0: MAX 15 wrap, d1: MAX 9 wrap, d2: MAX 9 saturate (all PRESCALE=1)
//   d3: MAX 15 wrap, PRESCALE=4
module tb_counter_updown_mod;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0, up = 1'b1, clr = 1'b0, load = 1'b0;
  logic [3:0] load_val = 4'd0;
  logic [3:0] c0, c1, c2, c3;
  logic       t0, t1, t2, t3, a0, a1, a2, a3;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int    id;
    int    c;
    bit    t;
    bit    a;
    string nm;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  counter_updown_mod #(.WIDTH(4), .MAX_VAL(15), .MODE(0), .PRESCALE(1)) d0 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .up(up), .clr(clr), .load(load),
    .load_val(load_val), .count(c0), .tc(t0), .at_limit(a0));
  counter_updown_mod #(.WIDTH(4), .MAX_VAL(9), .MODE(0), .PRESCALE(1)) d1 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .up(up), .clr(clr), .load(load),
    .load_val(load_val), .count(c1), .tc(t1), .at_limit(a1));
  counter_updown_mod #(.WIDTH(4), .MAX_VAL(9), .MODE(1), .PRESCALE(1)) d2 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .up(up), .clr(clr), .load(load),
    .load_val(load_val), .count(c2), .tc(t2), .at_limit(a2));
  counter_updown_mod #(.WIDTH(4), .MAX_VAL(15), .MODE(0), .PRESCALE(4)) d3 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .up(up), .clr(clr), .load(load),
    .load_val(load_val), .count(c3), .tc(t3), .at_limit(a3));

  task automatic chk(input string nm, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, req, $time);
    end
  endtask

  // Drive one cycle of inputs and queue what the target instance must show
  // after the next rising edge.
  task automatic cyc(input bit r, input bit en, input bit u, input bit c,
                     input bit l, input int lv, input int id, input int ec,
                     input bit et, input bit ea, input string nm);
    @(negedge clk);
    rst_n = r; enable = en; up = u; clr = c; load = l; load_val = 4'(lv);
    sb.push_back('{id, ec, et, ea, nm});
  endtask

  // Monitor: one expectation per rising edge, sampled just after it.
  initial begin
    exp_t e;
    int   ac, at, aa;
    forever begin
      @(posedge clk); #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        case (e.id)
          0:       begin ac = int'(c0); at = int'(t0); aa = int'(a0); end
          1:       begin ac = int'(c1); at = int'(t1); aa = int'(a1); end
          2:       begin ac = int'(c2); at = int'(t2); aa = int'(a2); end
          default: begin ac = int'(c3); at = int'(t3); aa = int'(a3); end
        endcase
        chk({e.nm, ".count"},    ac, e.c);
        chk({e.nm, ".tc"},       at, int'(e.t));
        chk({e.nm, ".at_limit"}, aa, int'(e.a));
      end
    end
  end

`ifdef COUNTER_PRESCALE_EN
  int pa[12] = '{0,0,0,1,1,1,1,2,2,2,2,3};
  int pb[12] = '{0,0,0,1,1,0,0,0,0,1,1,1};
`endif

  initial begin
    // 1: reset held two cycles, then wrap up through 15 -> 0 -> 1
    cyc(0,0,1,0,0,0, 0, 0,0,0, "rst0");
    cyc(0,0,1,0,0,0, 0, 0,0,0, "rst1");
    for (int i = 1; i <= 17; i++)
      cyc(1,1,1,0,0,0, 0, i % 16, (i == 16), ((i % 16) == 15), "t1");

    // 2: modulo-10 count down from load 2: 2,1,0,9,8
    cyc(1,0,0,0,1,2, 1, 2,0,0, "t2ld");
    cyc(1,1,0,0,0,0, 1, 1,0,0, "t2a");
    cyc(1,1,0,0,0,0, 1, 0,0,1, "t2b");
    cyc(1,1,0,0,0,0, 1, 9,1,0, "t2wrap");
    cyc(1,1,0,0,0,0, 1, 8,0,0, "t2c");

    // 3: saturate at 9 from load 7, then back down
    cyc(1,0,1,0,1,7, 2, 7,0,0, "t3ld");
    cyc(1,1,1,0,0,0, 2, 8,0,0, "t3a");
    cyc(1,1,1,0,0,0, 2, 9,1,1, "t3hit");
    cyc(1,1,1,0,0,0, 2, 9,0,1, "t3sat1");
    cyc(1,1,1,0,0,0, 2, 9,0,1, "t3sat2");
    cyc(1,1,1,0,0,0, 2, 9,0,1, "t3sat3");
    cyc(1,1,0,0,0,0, 2, 8,0,0, "t3dn1");
    cyc(1,1,0,0,0,0, 2, 7,0,0, "t3dn2");

    // 4: priority, load clamp, enable hold
    cyc(1,1,1,1,1,5, 1, 0,0,0, "t4clr");
    cyc(1,0,1,0,1,15,1, 9,0,1, "t4clamp");
    cyc(1,1,0,0,0,0, 1, 8,0,0, "t4dn1");
    cyc(1,1,0,0,0,0, 1, 7,0,0, "t4dn2");
    cyc(1,0,0,0,0,0, 1, 7,0,0, "t4hold1");
    cyc(1,0,0,0,0,0, 1, 7,0,0, "t4hold2");
    cyc(1,1,0,0,0,0, 1, 6,0,0, "t4dn3");

    // 5: asynchronous reset between edges with d1 at 6
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("t5.async_count", int'(c1), 0);
    chk("t5.async_tc",    int'(t1), 0);
    chk("t5.async_d2",    int'(c2), 0);
    cyc(1,1,1,0,0,0, 1, 1,0,0, "t5r1");
    cyc(1,1,1,0,0,0, 1, 2,0,0, "t5r2");

`ifdef COUNTER_PRESCALE_EN
    // 6: prescale 4, steps on every 4th enabled cycle; clr restarts it
    cyc(1,0,1,1,0,0, 3, 0,0,0, "t6clr");
    for (int i = 0; i < 12; i++)
      cyc(1,1,1,0,0,0, 3, pa[i],0,0, "t6a");
    cyc(1,0,1,1,0,0, 3, 0,0,0, "t6clr2");
    for (int i = 0; i < 12; i++)
      cyc(1,1,1,(i == 5),0,0, 3, pb[i],0,0, "t6b");
`else
    // Without the macro, PRESCALE is ignored: every enabled cycle steps.
    cyc(1,0,1,1,0,0, 3, 0,0,0, "t6clr");
    cyc(1,1,1,0,0,0, 3, 1,0,0, "t6s1");
    cyc(1,1,1,0,0,0, 3, 2,0,0, "t6s2");
    cyc(1,1,1,0,0,0, 3, 3,0,0, "t6s3");
`endif

    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/counter_updown_mod.md
Name: counter_updown_mod

Overview:
Parametrised up/down counter, next generation of the team's 4-bit enable counter. Adds configurable width, programmable modulo, direction control, synchronous clear/load and wrap-or-saturate mode. Adds a registered terminal-count pulse for chaining counters and for timer/divider blocks. Single clock domain; used standalone or cascaded via tc.

Parameters:
WIDTH, 4, counter width in bits (>=1).
MAX_VAL, 2**WIDTH-1, highest count value. Legal range 1 .. 2**WIDTH-1; elaboration error otherwise.
MODE, 0, 0 = wrap (modulo MAX_VAL+1); 1 = saturate at 0 / MAX_VAL.
PRESCALE, 4, enabled cycles per count step (>=1). Used only when COUNTER_PRESCALE_EN is defined.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
enable  input  1  count step request, sampled each rising edge
up  input  1  1 = count up, 0 = count down
clr  input  1  synchronous clear to 0
load  input  1  synchronous load of load_val
load_val  input  WIDTH  value for load
count  output  WIDTH  current count (registered)
tc  output  1  registered one-cycle terminal-count pulse
at_limit  output  1  combinational: (up && count==MAX_VAL) || (!up && count==0)

Behaviour:
- Clock: one clock clk. Reset: rst_n is asynchronous and active-low. Asserting rst_n low forces count=0, tc=0 and the prescaler to 0 immediately, without waiting for a clock edge. Release is synchronous to the next clk edge; the first step can occur on the first rising edge with rst_n high.
- Priority on each rising edge: clr > load > enable step > hold.
- clr=1: count<=0, tc<=0. load and enable are ignored.
- load=1 (clr=0): count<=min(load_val, MAX_VAL), tc<=0.
- enable=0 (no clr/load): count holds, tc<=0.
- Step, up=1, count<MAX_VAL: count<=count+1.
- Step, down (up=0), count>0: count<=count-1.
- Boundary, MODE=0 (wrap):
  - Up at MAX_VAL: count<=0, tc<=1.
  - Down at 0: count<=MAX_VAL, tc<=1.
- Boundary, MODE=1 (saturate):
  - A step that moves count into the limit (MAX_VAL-1 -> MAX_VAL up, 1 -> 0 down) sets tc<=1.
  - A step attempted while already at the limit holds count and sets tc<=0. No repeated pulses.
- tc is high for exactly one cycle, aligned with the count update that caused it. Any non-event cycle returns it to 0.
- Direction may change on any cycle. up is sampled together with enable; no pipeline bubble.
- Latency: count and tc change one clock after the inputs are sampled. at_limit has zero latency (combinational from count and up).
- Arithmetic: all comparisons are unsigned WIDTH-bit; no intermediate overflow. MAX_VAL=2**WIDTH-1 gives natural binary wrap.
- If rst_n asserts mid-sequence, all state is lost. No pending tc survives reset.

Optional Feature:
COUNTER_PRESCALE_EN
- Defined:
  - An internal prescaler of clog2(PRESCALE) bits counts enabled cycles. A count step occurs only on the enabled cycle where the prescaler equals PRESCALE-1; the prescaler then returns to 0.
  - enable=0 freezes the prescaler.
  - clr, load and rst_n reset the prescaler to 0.
  - PRESCALE=1 behaves identically to the undefined case.
- Undefined: no prescaler logic is generated. Every enabled cycle is a step; PRESCALE is ignored.

Test Plan:
1. Reset and wrap up: WIDTH=4, MAX_VAL=15, MODE=0. Hold rst_n=0 for 2 cycles, then enable=1, up=1 for 17 cycles -> count 0..15, 0, 1. tc=1 only on the 15->0 cycle; at_limit=1 while count=15.
2. Modulo down: MAX_VAL=9, MODE=0, load_val=2, load 1 cycle, then up=0, enable=1 -> count 2, 1, 0, 9, 8. tc pulses on the 0->9 cycle only.
3. Saturate: MAX_VAL=9, MODE=1, load_val=7, up=1, enable for 5 cycles -> count 8, 9, 9, 9, 9. tc=1 only on 8->9. Then up=0 for 2 cycles -> 8, 7, with tc=0 throughout.
4. Priority and clamp:
   - clr=1, load=1, enable=1 together -> count=0, tc=0.
   - Next cycle load=1, load_val=15 with MAX_VAL=9 -> count=9.
   - enable toggled low mid-count -> count holds, tc=0.
5. Async reset mid-run: count=6, drop rst_n between clock edges -> count=0 and tc=0 before the next rising edge. Counting resumes from 0 after release.
6. COUNTER_PRESCALE_EN defined, PRESCALE=4, enable=1, up=1 for 12 cycles -> count advances on cycles 4, 8 and 12 only (values 1, 2, 3). A clr asserted at cycle 6 resets the prescaler, so the next step occurs 4 enabled cycles after clr.
